// File: rtl/sfp_pkt_pkg.sv
// Shared packet definitions for the packet loader and the packet transmitter.
// Contents:
//   state_t    - loader FSM states
//   HDR_LEN_W  - width of the length field in the header word
//   hdr_t      - header word layout {reserved, byte length}
//   make_hdr() - builds a header word from a byte count
package sfp_pkt_pkg;

    localparam int HDR_LEN_W  = 16;
    localparam int CNT_W      = 12;
    localparam int RAM_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        HEADER,
        SEND,
        DROP
    } state_t;

    typedef struct packed {
        logic [31-HDR_LEN_W:0] rsvd;
        logic [HDR_LEN_W-1:0]  len;
    } hdr_t;

    function automatic logic [31:0] make_hdr(input logic [CNT_W-1:0] len);
        hdr_t h;
        h.rsvd = '0;
        h.len  = {{(HDR_LEN_W-CNT_W){1'b0}}, len};
        return h;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   data           - incoming byte
//   store          - accept data into the current lane this cycle
//   restart        - the byte being stored starts a new packet (lane 0)
//   word_next      - word as it looks with data placed in the current lane
//   be_next        - byte enables covering lanes 0..current lane
//   full           - the current lane is lane 3 (word completes on store)
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        store,
    input  logic        restart,
    output logic [31:0] word_next,
    output logic [3:0]  be_next,
    output logic        full
);

    logic [31:0] word_reg;
    logic [1:0]  lane_reg;
    logic [1:0]  lane_cur;

    assign lane_cur = restart ? 2'd0 : lane_reg;
    assign full     = (lane_cur == 2'd3);

    // Storing into lane 0 clears the upper lanes so a partial final word
    // never carries bytes left over from the previous word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = (lane_cur == 2'(gi)) ? data :
                                          ((lane_cur == 2'd0) ? 8'h00 : word_reg[gi*8 +: 8]);
            assign be_next[gi] = (lane_cur >= 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_reg <= '0;
            lane_reg <= '0;
        end else if (store) begin
            word_reg <= word_next;
            lane_reg <= lane_cur + 2'd1;
        end
    end

endmodule

// File: rtl/packet_loader.sv
// Loads byte-stream packets into ping-pong buffers of the shared packet RAM
// through an Avalon-MM write master, writes a length header, then launches
// the transmitter with a one-cycle cmd_send pulse.
// Ports:
//   clk_original, rst         - clock, synchronous active-low reset
//   in_data/valid/sop/eop     - byte stream in; in_ready = accept this cycle
//   ram_addr/chipselect/write/writedata/byteenable - zero-wait RAM writes
//   start_ram_addr, cmd_send  - header address of the launched packet + pulse
//   pkt_dropped               - pulse when a packet is discarded
module packet_loader
    import sfp_pkt_pkg::*;
#(
    parameter int BUF_WORDS = 512,
    parameter int MAX_BYTES = 4 * (BUF_WORDS - 1)
) (
    input  logic        clk_original,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [9:0]  ram_addr,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    output logic [3:0]  ram_byteenable,
    output logic [24:0] start_ram_addr,
    output logic        cmd_send,
    output logic        pkt_dropped
);

    localparam logic [RAM_ADDR_W-1:0] BASE1   = RAM_ADDR_W'(BUF_WORDS);
    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_BYTES);

    state_t                  state_reg;
    logic                    buf_sel_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    in_ready_reg;
    logic [RAM_ADDR_W-1:0]   ram_addr_reg;
    logic                    ram_write_reg;
    logic [31:0]             ram_writedata_reg;
    logic [3:0]              ram_byteenable_reg;
    logic [RAM_ADDR_W-1:0]   start_addr_reg;
    logic                    cmd_send_reg;
    logic                    pkt_dropped_reg;

    logic                    beat;
    logic                    at_max;
    logic                    store;
    logic                    issue_wr;
    logic [RAM_ADDR_W-1:0]   base;
    logic [RAM_ADDR_W-1:0]   pay_addr;
    logic [31:0]             word_next;
    logic [3:0]              be_next;
    logic                    full;

    assign beat   = in_valid && in_ready_reg;
    assign at_max = (count_reg == MAX_CNT);
    assign base   = buf_sel_reg ? BASE1 : '0;

    // Word of the byte being accepted; a sop byte is always byte 0.
    assign pay_addr = base + 10'd1 + (in_sop ? 10'd0 : count_reg[CNT_W-1:2]);

    // A byte is kept when it starts a packet, or extends one within limits.
    always_comb begin
        store = 1'b0;
        if (beat) begin
            if (state_reg == IDLE)
                store = in_sop;
            else if (state_reg == LOAD)
                store = in_sop || !at_max;
        end
    end

    // Completed words and the final (possibly partial) word go out on the
    // edge that accepts their last byte.
    assign issue_wr = store && (in_eop || full);

    byte_word_packer u_packer (
        .clk       (clk_original),
        .rst       (rst),
        .data      (in_data),
        .store     (store),
        .restart   (in_sop),
        .word_next (word_next),
        .be_next   (be_next),
        .full      (full)
    );

    always_ff @(posedge clk_original) begin
        if (!rst) begin
            state_reg          <= IDLE;
            buf_sel_reg        <= 1'b0;
            count_reg          <= '0;
            in_ready_reg       <= 1'b0;
            ram_addr_reg       <= '0;
            ram_write_reg      <= 1'b0;
            ram_writedata_reg  <= '0;
            ram_byteenable_reg <= '0;
            start_addr_reg     <= '0;
            cmd_send_reg       <= 1'b0;
            pkt_dropped_reg    <= 1'b0;
        end else begin
            ram_write_reg   <= 1'b0;
            cmd_send_reg    <= 1'b0;
            pkt_dropped_reg <= 1'b0;
            in_ready_reg    <= 1'b1;

            if (issue_wr) begin
                ram_write_reg      <= 1'b1;
                ram_addr_reg       <= pay_addr;
                ram_writedata_reg  <= word_next;
                ram_byteenable_reg <= be_next;
            end

            case (state_reg)
                IDLE: begin
                    if (beat && in_sop) begin
                        count_reg <= 12'd1;
                        if (in_eop) begin
                            state_reg    <= FLUSH;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (in_sop) begin
                            // Unterminated packet: abandon it, reuse the buffer.
                            pkt_dropped_reg <= 1'b1;
                            count_reg       <= 12'd1;
                            if (in_eop) begin
                                state_reg    <= FLUSH;
                                in_ready_reg <= 1'b0;
                            end
                        end else if (at_max) begin
                            if (in_eop) begin
                                pkt_dropped_reg <= 1'b1;
                                state_reg       <= IDLE;
                            end else begin
                                state_reg <= DROP;
                            end
                        end else begin
                            count_reg <= count_reg + 12'd1;
                            if (in_eop) begin
                                state_reg    <= FLUSH;
                                in_ready_reg <= 1'b0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    ram_write_reg      <= 1'b1;
                    ram_addr_reg       <= base;
                    ram_writedata_reg  <= make_hdr(count_reg);
                    ram_byteenable_reg <= 4'hF;
                    state_reg          <= HEADER;
                    in_ready_reg       <= 1'b0;
                end
                HEADER: begin
                    cmd_send_reg   <= 1'b1;
                    start_addr_reg <= base;
                    state_reg      <= SEND;
                    in_ready_reg   <= 1'b0;
                end
                SEND: begin
                    buf_sel_reg <= ~buf_sel_reg;
                    state_reg   <= IDLE;
                end
                DROP: begin
                    if (beat && in_eop) begin
                        pkt_dropped_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready       = in_ready_reg;
    assign ram_addr       = ram_addr_reg;
    assign ram_chipselect = ram_write_reg;
    assign ram_write      = ram_write_reg;
    assign ram_writedata  = ram_writedata_reg;
    assign ram_byteenable = ram_byteenable_reg;
    assign start_ram_addr = {15'd0, start_addr_reg};
    assign cmd_send       = cmd_send_reg;
    assign pkt_dropped    = pkt_dropped_reg;

endmodule

// File: tb/tb_packet_loader.sv
// Directed testbench for packet_loader: drives byte packets, mirrors RAM
// writes into a local memory image and checks headers, payload words,
// byte enables, launch pulses, drop pulses and reset behaviour.
module tb_packet_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;
    logic [9:0]  ram_addr;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [24:0] start_ram_addr;
    logic        cmd_send;
    logic        pkt_dropped;

    always #5 clk = ~clk;

    packet_loader #(.BUF_WORDS(512)) dut (
        .clk_original   (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_ready       (in_ready),
        .ram_addr       (ram_addr),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .start_ram_addr (start_ram_addr),
        .cmd_send       (cmd_send),
        .pkt_dropped    (pkt_dropped)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem    [0:1023];
    logic [3:0]  mem_be [0:1023];
    int          wr_seq = 0;
    int          n_send = 0;
    int          n_drop = 0;
    int          cs_bad = 0;
    logic [24:0] last_start = '0;

    // RAM model and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_write !== ram_chipselect) cs_bad++;
        if (ram_write === 1'b1) begin
            wr_seq++;
            for (int i = 0; i < 4; i++)
                if (ram_byteenable[i]) mem[ram_addr][i*8 +: 8] = ram_writedata[i*8 +: 8];
            mem_be[ram_addr] = ram_byteenable;
        end
        if (cmd_send === 1'b1) begin
            n_send++;
            last_start = start_ram_addr;
        end
        if (pkt_dropped === 1'b1) n_drop++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        #1;
    endtask

    int w0, s0, d0;

    initial begin
        rst      = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {13'd0, ram_write, ram_chipselect, cmd_send, pkt_dropped,
                           in_ready, ram_byteenable, ram_addr}, 32'd0);
        check("rst_wdata", ram_writedata, 32'd0);
        check("rst_start", start_ram_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        settle();

        // 8-byte packet 01..08 into buffer 0, with cycle-exact timing.
        w0 = wr_seq; s0 = n_send;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 1, 1'b0);
        @(negedge clk);
        check("t1_full_wr", ram_write, 32'd1);
        check("t1_full_addr", ram_addr, 32'd1);
        check("t1_full_data", ram_writedata, 32'h04030201);
        for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b0, i == 8);
        @(negedge clk);
        check("t1_flush_wr", ram_write, 32'd1);
        check("t1_flush_addr", ram_addr, 32'd2);
        check("t1_flush_data", ram_writedata, 32'h08070605);
        check("t1_flush_be", ram_byteenable, 32'hF);
        @(negedge clk);
        check("t1_hdr_wr", ram_write, 32'd1);
        check("t1_hdr_addr", ram_addr, 32'd0);
        check("t1_hdr_data", ram_writedata, 32'd8);
        @(negedge clk);
        check("t1_send", cmd_send, 32'd1);
        check("t1_start", start_ram_addr, 32'd0);
        check("t1_busy", in_ready, 32'd0);
        @(negedge clk);
        check("t1_ready_back", in_ready, 32'd1);
        check("t1_send_1cyc", cmd_send, 32'd0);
        settle();
        check("t1_mem0", mem[0], 32'd8);
        check("t1_mem1", mem[1], 32'h04030201);
        check("t1_mem2", mem[2], 32'h08070605);
        check("t1_nsend", n_send - s0, 32'd1);
        check("t1_nwr", wr_seq - w0, 32'd3);

        // Reset in the middle of a packet loading into buffer 1.
        s0 = n_send; d0 = n_drop;
        for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i), i == 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rmid_outs", {13'd0, ram_write, ram_chipselect, cmd_send, pkt_dropped,
                            in_ready, ram_byteenable, ram_addr}, 32'd0);
        check("rmid_wdata", ram_writedata, 32'd0);
        check("rmid_start", start_ram_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        settle();
        check("rmid_nsend", n_send - s0, 32'd0);
        check("rmid_ndrop", n_drop - d0, 32'd0);

        // 5-byte packet then 3-byte packet: buffer select restarts at 0.
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), i == 0, i == 4);
        settle();
        check("t2a_hdr", mem[0], 32'd5);
        check("t2a_w1", mem[1], 32'h14131211);
        check("t2a_w2", mem[2] & 32'hFF, 32'h15);
        check("t2a_be2", mem_be[2], 32'b0001);
        check("t2a_start", last_start, 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'h21 + 8'(i), i == 0, i == 2);
        settle();
        check("t2b_hdr", mem[512], 32'd3);
        check("t2b_w1", mem[513] & 32'h00FFFFFF, 32'h00232221);
        check("t2b_be", mem_be[513], 32'b0111);
        check("t2b_start", last_start, 32'd512);

        // sop on the third byte of an unterminated packet (buffer 0).
        d0 = n_drop; s0 = n_send;
        send_byte(8'h31, 1'b1, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h41, 1'b1, 1'b0);
        send_byte(8'h42, 1'b0, 1'b0);
        send_byte(8'h43, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b1);
        settle();
        check("t4_ndrop", n_drop - d0, 32'd1);
        check("t4_nsend", n_send - s0, 32'd1);
        check("t4_hdr", mem[0], 32'd4);
        check("t4_w1", mem[1], 32'h44434241);
        check("t4_start", last_start, 32'd0);

        // Beats without sop in IDLE are ignored.
        w0 = wr_seq; s0 = n_send;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0, i == 3);
        settle();
        check("t5_nwr", wr_seq - w0, 32'd0);
        check("t5_nsend", n_send - s0, 32'd0);
        check("t5_ready", in_ready, 32'd1);

        // 2045-byte packet into buffer 1: dropped, buffer kept.
        w0 = wr_seq; s0 = n_send; d0 = n_drop;
        for (int i = 0; i < 2045; i++) begin
            if (i == 2044) check("t6_no_early_drop", n_drop - d0, 32'd0);
            send_byte(8'(i), i == 0, i == 2044);
        end
        settle();
        check("t6_ndrop", n_drop - d0, 32'd1);
        check("t6_nsend", n_send - s0, 32'd0);
        check("t6_nwr", wr_seq - w0, 32'd511);
        send_byte(8'h51, 1'b1, 1'b0);
        send_byte(8'h52, 1'b0, 1'b1);
        settle();
        check("t6_next_hdr", mem[512], 32'd2);
        check("t6_next_w1", mem[513] & 32'h0000FFFF, 32'h00005251);
        check("t6_next_start", last_start, 32'd512);

        check("cs_follows_write", cs_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
